spi2dac: RTL and testbench

Serial DAC back end for the audio path. Accepts one 10-bit offset-binary sample per `load` pulse from the processing stage (`data_out` plus its sample strobe) and shifts it to an MCP4911-class SPI DAC as a 16-bit write command. It then pulses the DAC latch. It sits directly downstream of the echo/volume processor and is the last block before the board pins.

---
 rtl/spi2dac_if.sv | 41 ++++
 rtl/spi2dac.sv | 218 +++++++++++++++++++++
 tb/tb_spi2dac.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi2dac_if.sv
// -----------------------------------------------------------------------------
// spi2dac_if
//
// Sample hand-off between the echo/volume processor and the serial DAC back
// end. The processor drives one 10-bit offset-binary sample per load strobe
// and observes the transaction status returned by spi2dac.
//
// Signals
//   data_in [9:0]  processor -> DAC  offset-binary sample, valid with load
//   load           processor -> DAC  one-cycle sample strobe
//   busy           DAC -> processor  SPI transaction in progress
//   done           DAC -> processor  one-cycle pulse at end of transaction
//   overrun        DAC -> processor  one-cycle pulse, pending sample replaced
//
// Modports
//   master  processor side (drives data_in/load)
//   slave   spi2dac side (drives busy/done/overrun)
// -----------------------------------------------------------------------------
interface spi2dac_if;
    logic [9:0] data_in;
    logic       load;
    logic       busy;
    logic       done;
    logic       overrun;

    modport master (
        output data_in,
        output load,
        input  busy,
        input  done,
        input  overrun
    );

    modport slave (
        input  data_in,
        input  load,
        output busy,
        output done,
        output overrun
    );
endinterface

// File: rtl/spi2dac.sv
// -----------------------------------------------------------------------------
// spi2dac
//
// Serial DAC back end for the audio path. Each accepted 10-bit sample is sent
// to an MCP4911-class DAC as the 16-bit write command {CTRL, sample, 2'b00},
// MSB first, followed by an active-low LDAC pulse. A one-deep pending register
// absorbs a sample that arrives while a frame is still on the wire.
//
// Parameters
//   CLK_DIV  sysclk cycles per SPI half-period (>= 2); 25 -> 1 MHz SCK @ 50 MHz
//   CTRL     command bits [15:12] = {write, BUF, GA_n, SHDN_n}
//
// Ports
//   sysclk    in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   bus       if   spi2dac_if.slave (data_in, load, busy, done, overrun)
//   dac_cs_n  out  SPI chip select, active low
//   dac_sck   out  SPI clock, idle low; DAC samples SDI on the rising edge
//   dac_sdi   out  SPI data, MSB first
//   dac_ld_n  out  DAC latch strobe, active low
//
// Every output comes straight from a flop; nothing combinational reaches a pin.
// -----------------------------------------------------------------------------
module spi2dac #(
    parameter int         CLK_DIV = 25,
    parameter logic [3:0] CTRL    = 4'b0011
) (
    input  logic      sysclk,
    input  logic      rst_n,
    spi2dac_if.slave  bus,
    output logic      dac_cs_n,
    output logic      dac_sck,
    output logic      dac_sdi,
    output logic      dac_ld_n
);

    localparam int                DIV_W   = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        LATCH
    } state_t;

    state_t           state_q;
    logic [DIV_W-1:0] div_q;
    logic             tick;

    logic [15:0]      shreg_q;
    logic [4:0]       bit_cnt_q;

    logic [9:0]       pend_q;
    logic             pend_v_q;

    logic             cs_n_q;
    logic             sck_q;
    logic             sdi_q;
    logic             ld_n_q;
    logic             busy_q;
    logic             done_q;
    logic             overrun_q;

    logic [15:0]      launch_word_d;

    // -------------------------------------------------------------------------
    // Half-period divider. Held at zero in IDLE so every phase of a frame
    // starts with a full CLK_DIV-cycle interval.
    // -------------------------------------------------------------------------
    assign tick = (state_q != IDLE) && (div_q == DIV_MAX);

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else if (state_q == IDLE || tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Word to launch from IDLE: a waiting pending sample always goes first.
    // -------------------------------------------------------------------------
    // NOTE: the default assignment at the top keeps this block free of latches
    // whatever branch structure is added below it later.
    always_comb begin
        launch_word_d = {CTRL, bus.data_in, 2'b00};
        if (pend_v_q) begin
            launch_word_d = {CTRL, pend_q, 2'b00};
        end
    end

    // -------------------------------------------------------------------------
    // Pending sample buffer (depth 1).
    // A load is parked here whenever it cannot launch directly: while a frame
    // is in flight, or in the IDLE cycle that is itself launching the previous
    // pending sample. In the latter case the old value is leaving, so no
    // overrun is flagged.
    // -------------------------------------------------------------------------
    // NOTE: the pending data register has no reset; it is only ever read while
    // pend_v_q is set, and pend_v_q itself is reset.
    always_ff @(posedge sysclk) begin
        if (bus.load && (state_q != IDLE || pend_v_q)) begin
            pend_q <= bus.data_in;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            pend_v_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (state_q != IDLE) begin
                if (bus.load) begin
                    pend_v_q  <= 1'b1;
                    overrun_q <= pend_v_q;
                end
            end else if (pend_v_q) begin
                // Pending sample launches this cycle; a coincident load
                // refills the slot.
                pend_v_q <= bus.load;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Transaction FSM with registered pin outputs.
    // Pin changes are scheduled on the transition into a state, so e.g.
    // dac_ld_n goes low on the same edge that dac_cs_n returns high.
    // -------------------------------------------------------------------------
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            cs_n_q    <= 1'b1;
            sck_q     <= 1'b0;
            sdi_q     <= 1'b0;
            ld_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (pend_v_q || bus.load) begin
                        shreg_q <= launch_word_d;
                        sdi_q   <= launch_word_d[15];
                        cs_n_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= CS_SETUP;
                    end
                end

                CS_SETUP: begin
                    if (tick) begin
                        bit_cnt_q <= 5'd16;
                        sck_q     <= 1'b0;
                        state_q   <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (tick) begin
                        sck_q <= ~sck_q;
                        // Data only moves on the falling toggle, giving a full
                        // half-period of setup and hold around each rise.
                        if (sck_q) begin
                            shreg_q   <= {shreg_q[14:0], 1'b0};
                            sdi_q     <= shreg_q[14];
                            bit_cnt_q <= bit_cnt_q - 5'd1;
                            if (bit_cnt_q == 5'd1) begin
                                state_q <= CS_HOLD;
                            end
                        end
                    end
                end

                CS_HOLD: begin
                    if (tick) begin
                        cs_n_q  <= 1'b1;
                        ld_n_q  <= 1'b0;
                        state_q <= LATCH;
                    end
                end

                LATCH: begin
                    if (tick) begin
                        ld_n_q  <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dac_cs_n    = cs_n_q;
    assign dac_sck     = sck_q;
    assign dac_sdi     = sdi_q;
    assign dac_ld_n    = ld_n_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_spi2dac.sv
// -----------------------------------------------------------------------------
// tb_spi2dac
//
// Directed bench for spi2dac. dut0 uses the default CLK_DIV=25, dut1 uses
// CLK_DIV=2 for the back-to-back streaming case. A passive SPI monitor per DUT
// (sampled on the falling sysclk edge) reassembles frames and records timing;
// the directed sequence compares those records with hand-computed values.
//
// Cycle bookkeeping: cyc counts rising edges. A value recorded as cyc == k
// became visible just after rising edge k. le is the edge that sampled load.
// -----------------------------------------------------------------------------
module tb_spi2dac;

    localparam int CD0 = 25;
    localparam int CD1 = 2;

    logic sysclk = 1'b0;
    logic rst_n  = 1'b0;

    always #5 sysclk = ~sysclk;

    spi2dac_if if0 ();
    spi2dac_if if1 ();

    logic cs_n0, sck0, sdi0, ld_n0;
    logic cs_n1, sck1, sdi1, ld_n1;

    spi2dac #(.CLK_DIV(CD0)) dut0 (
        .sysclk   (sysclk),
        .rst_n    (rst_n),
        .bus      (if0),
        .dac_cs_n (cs_n0),
        .dac_sck  (sck0),
        .dac_sdi  (sdi0),
        .dac_ld_n (ld_n0)
    );

    spi2dac #(.CLK_DIV(CD1)) dut1 (
        .sysclk   (sysclk),
        .rst_n    (rst_n),
        .bus      (if1),
        .dac_cs_n (cs_n1),
        .dac_sck  (sck1),
        .dac_sdi  (sdi1),
        .dac_ld_n (ld_n1)
    );

    int cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    // ---------------------------------------------------------------- monitor
    int          n_fall     [2] = '{0, 0};
    int          n_done     [2] = '{0, 0};
    int          n_brise    [2] = '{0, 0};
    int          rises      [2] = '{0, 0};
    int          ovr_cnt    [2] = '{0, 0};
    int          ld_pulses  [2] = '{0, 0};
    int          ld_len     [2] = '{0, 0};
    int          ld_start   [2] = '{0, 0};
    int          ld_cs_viol [2] = '{0, 0};
    int          setup_viol [2] = '{0, 0};
    int          hold_viol  [2] = '{0, 0};
    int          last_chg   [2] = '{0, 0};
    int          last_rise  [2] = '{0, 0};
    logic [15:0] sh         [2] = '{16'h0, 16'h0};
    logic [6:0]  prev       [2] = '{7'b1001000, 7'b1001000};

    logic [15:0] fr_word  [2][16];
    int          fr_rises [2][16];
    int          fr_first [2][16];
    int          fall_c   [2][16];
    int          done_c   [2][16];
    int          brise_c  [2][16];

    // sample bits: 6 cs_n, 5 sck, 4 sdi, 3 ld_n, 2 busy, 1 done, 0 overrun
    always @(negedge sysclk) begin
        logic [6:0] s;
        int         cd;
        for (int i = 0; i < 2; i++) begin
            s  = (i == 0) ? {cs_n0, sck0, sdi0, ld_n0, if0.busy, if0.done, if0.overrun}
                          : {cs_n1, sck1, sdi1, ld_n1, if1.busy, if1.done, if1.overrun};
            cd = (i == 0) ? CD0 : CD1;

            if (prev[i][6] && !s[6]) begin
                if (n_fall[i] < 16) fall_c[i][n_fall[i]] = cyc;
                n_fall[i]++;
                sh[i]    = '0;
                rises[i] = 0;
            end
            if (!s[6] && (s[4] != prev[i][4])) begin
                if (rises[i] > 0 && (cyc - last_rise[i]) < cd - 1) hold_viol[i]++;
                last_chg[i] = cyc;
            end
            if (!s[6] && !prev[i][5] && s[5]) begin
                if ((cyc - last_chg[i]) < cd - 1) setup_viol[i]++;
                sh[i] = {sh[i][14:0], s[4]};
                if (rises[i] == 0 && n_fall[i] > 0 && n_fall[i] <= 16) fr_first[i][n_fall[i]-1] = cyc;
                rises[i]++;
                last_rise[i] = cyc;
            end
            if (!prev[i][6] && s[6] && n_fall[i] > 0 && n_fall[i] <= 16) begin
                fr_word[i][n_fall[i]-1]  = sh[i];
                fr_rises[i][n_fall[i]-1] = rises[i];
            end
            if (prev[i][3] && !s[3]) begin
                ld_start[i] = cyc;
                if (!s[6]) ld_cs_viol[i]++;
            end
            if (!prev[i][3] && s[3]) begin
                ld_len[i] = cyc - ld_start[i];
                ld_pulses[i]++;
            end
            if (s[1]) begin
                if (n_done[i] < 16) done_c[i][n_done[i]] = cyc;
                n_done[i]++;
            end
            if (!prev[i][2] && s[2]) begin
                if (n_brise[i] < 16) brise_c[i][n_brise[i]] = cyc;
                n_brise[i]++;
            end
            if (s[0]) ovr_cnt[i]++;
            prev[i] = s;
        end
    end

    // ---------------------------------------------------------------- helpers
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    // Drive a one-cycle load; le returns the rising edge that samples it.
    task automatic load_dut(input int inst, input logic [9:0] d, output int le);
        @(posedge sysclk);
        #1;
        if (inst == 0) begin
            if0.data_in = d;
            if0.load    = 1'b1;
        end else begin
            if1.data_in = d;
            if1.load    = 1'b1;
        end
        le = cyc + 1;
        @(posedge sysclk);
        #1;
        if0.load = 1'b0;
        if1.load = 1'b0;
    endtask

    task automatic wait_done(input int inst, input int target, input int budget, input string tag);
        int k = 0;
        while (n_done[inst] < target && k < budget) begin
            @(posedge sysclk);
            #1;
            k++;
        end
        check(tag, 32'(n_done[inst] >= target), 32'd1);
    endtask

    // ---------------------------------------------------------------- watchdog
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- sequence
    logic [9:0]  dat1 [6] = '{10'h001, 10'h2AA, 10'h3FF, 10'h200, 10'h155, 10'h0F0};
    logic [15:0] exp1 [6] = '{16'h3004, 16'h3AA8, 16'h3FFC, 16'h3800, 16'h3554, 16'h33C0};

    initial begin
        int le;
        int e;
        int k;
        int pulses_before;

        if0.load = 1'b0; if0.data_in = '0;
        if1.load = 1'b0; if1.data_in = '0;

        // Reset state of both instances.
        wait_cycles(3);
        check("reset_pins_dut0", 32'({cs_n0, sck0, sdi0, ld_n0, if0.busy, if0.done, if0.overrun}), 32'h48);
        check("reset_pins_dut1", 32'({cs_n1, sck1, sdi1, ld_n1, if1.busy, if1.done, if1.overrun}), 32'h48);
        @(negedge sysclk);
        rst_n = 1'b1;
        wait_cycles(3);

        // Single frame, 10'h200 -> 16'h3800, full timing.
        load_dut(0, 10'h200, le);
        check("busy_after_load", 32'(if0.busy), 32'd1);
        check("cs_low_after_load", 32'(cs_n0), 32'd0);
        wait_done(0, 1, 2000, "done_timeout_f0");
        check("frame0_word", 32'(fr_word[0][0]), 32'h3800);
        check("frame0_sck_rises", fr_rises[0][0], 32'd16);
        check("frame0_cs_fall", fall_c[0][0] - le, 32'd0);
        check("frame0_first_rise", fr_first[0][0] - le, 32'(2 * CD0));
        check("frame0_done_latency", done_c[0][0] - le, 32'(35 * CD0));
        check("frame0_ld_len", ld_len[0], 32'(CD0));
        check("frame0_ld_pulses", ld_pulses[0], 32'd1);
        check("busy_low_after_done", 32'(if0.busy), 32'd0);

        // All-ones and all-zeros samples.
        load_dut(0, 10'h3FF, le);
        wait_done(0, 2, 2000, "done_timeout_f1");
        load_dut(0, 10'h000, le);
        wait_done(0, 3, 2000, "done_timeout_f2");
        check("frame1_word", 32'(fr_word[0][1]), 32'h3FFC);
        check("frame2_word", 32'(fr_word[0][2]), 32'h3000);
        check("frame2_sck_rises", fr_rises[0][2], 32'd16);
        check("sdi_setup_dut0", setup_viol[0], 32'd0);
        check("sdi_hold_dut0", hold_viol[0], 32'd0);
        check("done_one_cycle", n_done[0], 32'd3);
        check("ld_while_cs_low", ld_cs_viol[0], 32'd0);

        // One pending sample launches at done+1 with no overrun.
        load_dut(0, 10'h200, le);
        wait_cycles(100);
        load_dut(0, 10'h155, le);
        check("pending_no_overrun_now", 32'(if0.overrun), 32'd0);
        wait_done(0, 5, 4000, "done_timeout_f4");
        check("frame3_word", 32'(fr_word[0][3]), 32'h3800);
        check("frame4_word", 32'(fr_word[0][4]), 32'h3554);
        check("pending_start_after_done", fall_c[0][4] - done_c[0][3], 32'd1);
        check("pending_overrun_count", ovr_cnt[0], 32'd0);

        // Two loads during one frame: second overwrites first, overrun once.
        load_dut(0, 10'h3FF, le);
        wait_cycles(50);
        load_dut(0, 10'h0AA, le);
        check("first_pending_no_overrun", 32'(if0.overrun), 32'd0);
        wait_cycles(50);
        load_dut(0, 10'h111, le);
        check("overwrite_overrun_pulse", 32'(if0.overrun), 32'd1);
        wait_done(0, 7, 4000, "done_timeout_f6");
        wait_cycles(200);
        check("overrun_once", ovr_cnt[0], 32'd1);
        check("frame5_word", 32'(fr_word[0][5]), 32'h3FFC);
        check("frame6_word", 32'(fr_word[0][6]), 32'h3444);
        check("no_frame_for_dropped", n_fall[0], 32'd7);

        // Reset at bit 7 aborts without an LD pulse.
        load_dut(0, 10'h200, le);
        k = 0;
        while (rises[0] < 7 && k < 2000) begin
            @(posedge sysclk);
            #1;
            k++;
        end
        check("reached_bit7", 32'(rises[0] >= 7), 32'd1);
        pulses_before = ld_pulses[0];
        @(negedge sysclk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_pins", 32'({cs_n0, sck0, if0.busy}), 32'h4);
        wait_cycles(3);
        @(negedge sysclk);
        rst_n = 1'b1;
        wait_cycles(100);
        check("abort_no_ld_pulse", ld_pulses[0], pulses_before);
        check("abort_no_done", n_done[0], 32'd7);
        load_dut(0, 10'h200, le);
        wait_done(0, 8, 2000, "done_timeout_f8");
        check("after_abort_word", 32'(fr_word[0][8]), 32'h3800);
        check("after_abort_rises", fr_rises[0][8], 32'd16);
        check("after_abort_done_latency", done_c[0][7] - le, 32'(35 * CD0));

        // CLK_DIV=2, a load every 70 cycles.
        wait_cycles(5);
        e = cyc;
        for (int f = 0; f < 6; f++) begin
            while (cyc < e + 70 * f) begin
                @(posedge sysclk);
                #1;
            end
            load_dut(1, dat1[f], le);
        end
        wait_done(1, 6, 2000, "done_timeout_dut1");
        for (int f = 0; f < 6; f++) begin
            check($sformatf("dut1_frame%0d_word", f), 32'(fr_word[1][f]), 32'(exp1[f]));
            check($sformatf("dut1_frame%0d_rises", f), fr_rises[1][f], 32'd16);
            if (f > 0) begin
                check($sformatf("dut1_busy_gap%0d", f), brise_c[1][f] - done_c[1][f-1], 32'd1);
            end
        end
        check("dut1_no_overrun", ovr_cnt[1], 32'd0);
        check("dut1_frame_count", n_fall[1], 32'd6);
        check("sdi_setup_dut1", setup_viol[1], 32'd0);
        check("sdi_hold_dut1", hold_viol[1], 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
